// File: rtl/pkt_sf_buffer.sv
`default_nettype none
// ============================================================================
// Module      : pkt_sf_buffer
// Description : Store-and-forward packet buffer. Releases only complete
//               packets and drops packets that do not fit. The optional
//               drop/error statistics counters are built when
//               PKT_SF_STATS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pkt_sf_buffer #(
    parameter  int DW    = 32,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_sop,
    input  logic          in_eop,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_sop,
    output logic          out_eop,
    output logic [AW:0]   pkt_cnt,
    output logic [15:0]   drop_cnt,
    output logic [15:0]   err_cnt
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_RECV    = 2'd1;
    localparam logic [1:0]  c_DISCARD = 2'd2;
    localparam logic [AW:0] c_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_ONE     = (AW+1)'(1);

    logic [DW+1:0] r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr, r_commit_ptr, r_rd_ptr, r_pkt_cnt;
    logic [1:0]    r_state;
    logic          r_in_ready;

    logic [AW:0]   w_base;
    logic [DW+1:0] w_rd_word;
    logic [1:0]    w_state_nxt;
    logic          w_accept, w_full, w_write, w_commit, w_drop, w_err, w_rd;

    assign w_accept  = in_valid & r_in_ready;
    // A sop arriving mid-packet abandons the partial packet before it is stored.
    assign w_base    = (r_state == c_RECV && in_sop) ? r_commit_ptr : r_wr_ptr;
    assign w_full    = ((w_base - r_rd_ptr) == c_DEPTH);
    assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];
    assign w_rd      = out_valid & out_ready;

    always_comb begin
        w_write     = 1'b0;
        w_commit    = 1'b0;
        w_drop      = 1'b0;
        w_err       = 1'b0;
        w_state_nxt = r_state;
        if (w_accept) begin
            if (in_sop) begin
                w_err = (r_state != c_IDLE);
                if (!w_full) begin
                    w_write     = 1'b1;
                    w_commit    = in_eop;
                    w_state_nxt = in_eop ? c_IDLE : c_RECV;
                end else begin
                    w_drop      = 1'b1;
                    w_state_nxt = in_eop ? c_IDLE : c_DISCARD;
                end
            end else begin
                case (r_state)
                    c_IDLE: w_err = 1'b1;
                    c_RECV: begin
                        if (!w_full) begin
                            w_write  = 1'b1;
                            w_commit = in_eop;
                            if (in_eop) w_state_nxt = c_IDLE;
                        end else begin
                            w_drop      = 1'b1;
                            w_state_nxt = in_eop ? c_IDLE : c_DISCARD;
                        end
                    end
                    default: if (in_eop) w_state_nxt = c_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_in_ready   <= 1'b0;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_rd_ptr     <= '0;
            r_pkt_cnt    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= 1'b1;
            if (w_write)
                r_wr_ptr <= w_base + c_ONE;
            else if (w_drop)
                r_wr_ptr <= r_commit_ptr;
            if (w_commit)
                r_commit_ptr <= w_base + c_ONE;
            if (w_rd)
                r_rd_ptr <= r_rd_ptr + c_ONE;
            case ({w_commit, w_rd & out_eop})
                2'b10:   r_pkt_cnt <= r_pkt_cnt + c_ONE;
                2'b01:   r_pkt_cnt <= r_pkt_cnt - c_ONE;
                default: r_pkt_cnt <= r_pkt_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_write)
            r_mem[w_base[AW-1:0]] <= {in_sop, in_eop, in_data};
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_rd_ptr != r_commit_ptr);
    assign out_data  = out_valid ? w_rd_word[DW-1:0] : '0;
    assign out_sop   = out_valid & w_rd_word[DW+1];
    assign out_eop   = out_valid & w_rd_word[DW];
    assign pkt_cnt   = r_pkt_cnt;

`ifdef PKT_SF_STATS_EN
    logic [15:0] r_drop_cnt, r_err_cnt;

    // Both counters hold at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop_cnt <= '0;
            r_err_cnt  <= '0;
        end else begin
            if (w_drop && r_drop_cnt != 16'hFFFF)
                r_drop_cnt <= r_drop_cnt + 16'd1;
            if (w_err && r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
    assign err_cnt  = r_err_cnt;
`else
    logic w_stats_unused;
    assign w_stats_unused = w_drop | w_err;
    assign drop_cnt       = '0;
    assign err_cnt        = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pkt_sf_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pkt_sf_buffer
// Description : Directed self-checking bench for pkt_sf_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pkt_sf_buffer;

`ifdef PKT_SF_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_sop, in_eop, out_ready;
    logic [31:0] in_data;
    logic        in_ready, out_valid, out_sop, out_eop;
    logic [31:0] out_data;
    logic [4:0]  pkt_cnt;
    logic [15:0] drop_cnt, err_cnt;

    int checks = 0;
    int errors = 0;

    pkt_sf_buffer #(.DW(32), .DEPTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v, s, e;
        logic [31:0] d;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        logic        es, ee;
        int          epk, eerr;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic e, input logic [31:0] d);
        in_valid = v;
        in_sop   = s;
        in_eop   = e;
        in_data  = d;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_flags", {30'd0, out_sop, out_eop}, 0);
        chk("rst_pkt_cnt", {27'd0, pkt_cnt}, 0);
        chk("rst_drop_cnt", {16'd0, drop_cnt}, 0);
        chk("rst_err_cnt", {16'd0, err_cnt}, 0);
        rst = 1'b0;
        tick();
        chk("in_ready_after_rst", {31'd0, in_ready}, 1);
    endtask

    task automatic check_out(input string tag, input logic ev, input logic [31:0] ed,
                             input logic es, input logic ee);
        chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, ev});
        if (ev) begin
            chk({tag, "_data"}, out_data, ed);
            chk({tag, "_sop_eop"}, {30'd0, out_sop, out_eop}, {30'd0, es, ee});
        end
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        drive(0, 0, 0, 0);

        // 3-beat packet, then a truncated 4-beat packet followed by a 1-beat packet
        tbl[0]  = '{1, 1, 0, 32'h11, 1, 0, 0,     0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 32'h22, 1, 0, 0,     0, 0, 0, 0};
        tbl[2]  = '{1, 0, 1, 32'h33, 1, 0, 0,     0, 0, 0, 0};
        tbl[3]  = '{0, 0, 0, 32'h0,  1, 1, 32'h11, 1, 0, 1, 0};
        tbl[4]  = '{0, 0, 0, 32'h0,  1, 1, 32'h22, 0, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 32'h0,  1, 1, 32'h33, 0, 1, 1, 0};
        tbl[6]  = '{1, 1, 0, 32'hA1, 1, 0, 0,     0, 0, 0, 0};
        tbl[7]  = '{1, 0, 0, 32'hA2, 1, 0, 0,     0, 0, 0, 0};
        tbl[8]  = '{1, 0, 0, 32'hA3, 1, 0, 0,     0, 0, 0, 0};
        tbl[9]  = '{1, 0, 0, 32'hA4, 1, 0, 0,     0, 0, 0, 0};
        tbl[10] = '{1, 1, 1, 32'hB1, 1, 0, 0,     0, 0, 0, 0};
        tbl[11] = '{0, 0, 0, 32'h0,  1, 1, 32'hB1, 1, 1, 1, 1};
        tbl[12] = '{0, 0, 0, 32'h0,  1, 0, 0,     0, 0, 0, 1};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].d);
            out_ready = tbl[i].rdy;
            check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].es, tbl[i].ee);
            chk($sformatf("vec%0d_pkt_cnt", i), {27'd0, pkt_cnt}, tbl[i].epk);
            chk($sformatf("vec%0d_err_cnt", i), {16'd0, err_cnt}, tbl[i].eerr * STATS);
            tick();
        end

        // Oversized 20-beat packet dropped, following 2-beat packet kept
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1, i == 0, i == 19, 32'h100 + i);
            tick();
        end
        drive(1, 1, 0, 32'h200); tick();
        drive(1, 0, 1, 32'h201); tick();
        drive(0, 0, 0, 0);
        chk("ovf_pkt_cnt", {27'd0, pkt_cnt}, 1);
        chk("ovf_drop_cnt", {16'd0, drop_cnt}, 1 * STATS);
        check_out("ovf_b0_held", 1, 32'h200, 1, 0);
        out_ready = 1'b1;
        check_out("ovf_b0", 1, 32'h200, 1, 0); tick();
        check_out("ovf_b1", 1, 32'h201, 0, 1); tick();
        check_out("ovf_empty", 0, 0, 0, 0);
        chk("ovf_pkt_cnt_end", {27'd0, pkt_cnt}, 0);

        // Exact fill with four 4-beat packets, fifth dropped, then drain in order
        do_reset();
        out_ready = 1'b0;
        for (int p = 0; p < 5; p++)
            for (int b = 0; b < 4; b++) begin
                drive(1, b == 0, b == 3, (p < 4) ? 32'(p * 16 + b) : 32'hEE);
                tick();
            end
        drive(0, 0, 0, 0);
        chk("fill_pkt_cnt", {27'd0, pkt_cnt}, 4);
        chk("fill_drop_cnt", {16'd0, drop_cnt}, 1 * STATS);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_out($sformatf("drain%0d", i), 1, 32'((i / 4) * 16 + (i % 4)),
                      (i % 4) == 0, (i % 4) == 3);
            tick();
        end
        check_out("drain_empty", 0, 0, 0, 0);
        chk("drain_pkt_cnt", {27'd0, pkt_cnt}, 0);

        // Back-to-back 1-beat packets: commit and output eop in the same cycle
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 1, 32'h50 + i);
            if (i >= 1) begin
                check_out($sformatf("b2b%0d", i), 1, 32'h50 + i - 1, 1, 1);
                chk($sformatf("b2b%0d_pkt_cnt", i), {27'd0, pkt_cnt}, 1);
            end
            tick();
        end
        drive(0, 0, 0, 0);
        check_out("b2b_last", 1, 32'h57, 1, 1); tick();
        check_out("b2b_empty", 0, 0, 0, 0);
        chk("b2b_pkt_cnt_end", {27'd0, pkt_cnt}, 0);

        // Reset in the middle of a packet, then a clean packet
        drive(1, 1, 0, 32'h61); tick();
        drive(1, 0, 0, 32'h62); tick();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        chk("midrst_in_ready", {31'd0, in_ready}, 0);
        chk("midrst_out_valid", {31'd0, out_valid}, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_pkt_cnt", {27'd0, pkt_cnt}, 0);
        rst = 1'b0;
        tick();
        drive(1, 1, 0, 32'h71); tick();
        drive(1, 0, 1, 32'h72); tick();
        drive(0, 0, 0, 0);
        check_out("clean_b0", 1, 32'h71, 1, 0); tick();
        check_out("clean_b1", 1, 32'h72, 0, 1); tick();
        check_out("clean_empty", 0, 0, 0, 0);
        chk("clean_err_cnt", {16'd0, err_cnt}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pkt_sf_buffer.md
Name: pkt_sf_buffer

Overview:
- Store-and-forward packet buffer for the RTL side of the TLM packet path.
- Sits directly downstream of the SV consumer transactor, which drives each received packet transaction as a beat stream.
- Accepts beats, holds each packet until its final beat arrives, then releases only complete packets to the DUT.
- Drops packets that do not fit and counts drops and framing errors.

Parameters:
- DW, 32: data beat width in bits.
- DEPTH, 16: buffer depth in beats. Must be a power of 2 and at least 4. Derived localparam AW = log2(DEPTH).

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input ready. Held at 1 whenever out of reset; the block never backpressures and drops on overflow instead.
- in_data  in  DW  input beat data.
- in_sop  in  1  first beat of packet.
- in_eop  in  1  last beat of packet. sop and eop may both be set for a 1-beat packet.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DW  output beat data.
- out_sop  out  1  output first beat.
- out_eop  out  1  output last beat.
- pkt_cnt  out  AW+1  number of complete packets currently buffered.
- drop_cnt  out  16  packets dropped for lack of space.
- err_cnt  out  16  framing errors.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: in_ready=0, out_valid=0, out_data/out_sop/out_eop=0, pkt_cnt=0, drop_cnt=0, err_cnt=0. All pointers 0, FSM in IDLE.
- Reset mid-packet: the partial packet and all buffered data are discarded.
- Storage:
  - DEPTH x (DW+2) array holding data, sop and eop per beat.
  - Three pointers, each AW+1 bits with wrap bit: wr_ptr, commit_ptr, rd_ptr.
  - free = DEPTH - (wr_ptr - rd_ptr), computed modulo 2^(AW+1). Uncommitted beats occupy space.
- Input accept: a beat is taken when in_valid=1 and in_ready=1.
- FSM states: IDLE, RECV, DISCARD.
  - IDLE, beat with sop:
    - If free>0: write the beat. If eop is also set, commit (commit_ptr<=wr_ptr+1) and stay in IDLE; otherwise go to RECV.
    - If free=0: drop_cnt++, go to DISCARD, or stay in IDLE if eop.
  - IDLE, beat without sop: err_cnt++, discard the beat, stay in IDLE.
  - RECV, beat without sop:
    - If free>0: write the beat. On eop, commit and go to IDLE.
    - If free=0: wr_ptr<=commit_ptr (rewind), drop_cnt++, go to DISCARD, or IDLE if this beat is eop.
  - RECV, beat with sop: err_cnt++, rewind wr_ptr to commit_ptr, then process the beat exactly as an IDLE sop beat in the same cycle.
  - DISCARD: ignore beats. On eop go to IDLE. A sop beat here gives err_cnt++ and is processed as an IDLE sop.
- Packets longer than DEPTH beats are always dropped.
- Output:
  - First-word-fall-through from mem[rd_ptr].
  - out_valid = (rd_ptr != commit_ptr). Only committed beats are visible.
  - rd_ptr advances on out_valid && out_ready.
- Latency: if the eop beat is accepted in cycle N, the packet's first beat presents out_valid in cycle N+1. Output throughput is 1 beat/cycle.
- pkt_cnt: +1 on commit, -1 on an output handshake with out_eop. If both happen in the same cycle, pkt_cnt is unchanged.
- Simultaneous read and write: space freed by a read in cycle N becomes usable for writes in cycle N+1, not in cycle N.
- Counters saturate at 16'hFFFF and do not wrap.

Optional Feature:
- Macro: PKT_SF_STATS_EN.
- Defined: drop_cnt and err_cnt are live saturating counters as specified above.
- Undefined: the counter registers are not built, drop_cnt and err_cnt are tied to 0, and drop/discard behaviour is otherwise identical.

Test Plan:
- 3-beat packet (sop D0=0x11, 0x22, eop 0x33), out_ready=1 -> out beats 0x11/0x22/0x33 beginning the cycle after the eop beat; sop/eop flags correct; pkt_cnt pulses 1 then returns to 0.
- DEPTH=16, out_ready=0, send a 20-beat packet then a 2-beat packet -> 20-beat packet dropped, drop_cnt=1; 2-beat packet buffered, pkt_cnt=1; out_valid=1 with first beat of the 2-beat packet.
- 4-beat packet missing eop, followed by a new sop 1-beat packet -> err_cnt=1; only the 1-beat packet is output; no stale beats appear.
- out_ready=0, four 4-beat packets fill the buffer exactly -> pkt_cnt=4, no drop. A 5th packet is then dropped, drop_cnt=1. Release out_ready -> 16 beats delivered in order.
- Continuous 1-beat packets with out_ready=1 -> a commit and an output eop occur in the same cycle; pkt_cnt stays constant; throughput is 1 packet/cycle.
- rst asserted after 2 beats of a 5-beat packet -> the following cycle shows all outputs 0. A subsequent clean packet passes through unchanged.
- Build without PKT_SF_STATS_EN, repeat the overflow scenario -> same data output, drop_cnt=0.
